// File: rtl/pipeline_hazard_unit_pkg.sv
// rtl/pipeline_hazard_unit_pkg.sv - shared types for the hazard/forwarding controller
package cpu_types_pkg;

   // Tags carry register addresses zero-extended to this width.
   localparam int REG_AW_MAX = 8;

   typedef logic [REG_AW_MAX-1:0] regbits_t;

   // One in-flight result stage as seen from ID.
   typedef struct packed {
      logic     valid;
      regbits_t rd;
      logic     regwrite;
      logic     memread;
      logic     halt;
   } hz_tag_t;

   // Forward-select value meaning "read the register file".
   localparam int FWD_RF = 0;

endpackage

// File: rtl/pipeline_hazard_unit_if.sv
// rtl/pipeline_hazard_unit_if.sv - ID-side hazard bundle between datapath and controller
interface pipeline_hazard_unit_if #(
   parameter int NUM_STAGES = 3,
   parameter int NUM_SRC    = 2,
   parameter int REG_AW     = 5
);
   localparam int FW = $clog2(NUM_STAGES + 1);

   logic                      id_valid;
   logic [NUM_SRC*REG_AW-1:0] id_rs;
   logic [NUM_SRC-1:0]        id_rs_used;
   logic [REG_AW-1:0]         id_rd;
   logic                      id_regwrite;
   logic                      id_memread;
   logic                      id_halt;
   logic                      redirect;
   logic                      imem_wait;
   logic                      dmem_wait;
   logic                      pc_write;
   logic                      if_id_write;
   logic                      if_id_flush;
   logic                      id_ex_bubble;
   logic                      pipe_adv;
   logic [NUM_SRC*FW-1:0]     fwd_sel;
   logic                      stall;
   logic                      halted;

   modport master (
      output id_valid, id_rs, id_rs_used, id_rd, id_regwrite, id_memread, id_halt,
      output redirect, imem_wait, dmem_wait,
      input  pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_adv,
      input  fwd_sel, stall, halted
   );

   modport slave (
      input  id_valid, id_rs, id_rs_used, id_rd, id_regwrite, id_memread, id_halt,
      input  redirect, imem_wait, dmem_wait,
      output pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_adv,
      output fwd_sel, stall, halted
   );
endinterface

// File: rtl/hazard_src_match.sv
// rtl/hazard_src_match.sv - youngest-producer lookup for one source operand
module hazard_src_match
   import cpu_types_pkg::*;
#(
   parameter int NUM_STAGES = 3,
   parameter int LOAD_STAGE = 1,
   parameter int IW         = 2
) (
   input  hz_tag_t [NUM_STAGES-1:0] i_tags,
   input  regbits_t                 i_rs,
   input  logic                     i_used,
   output logic [IW-1:0]            o_idx,
   output logic                     o_match,
   output logic                     o_avail
);

   logic          w_match;
   logic          w_avail;
   logic [IW-1:0] w_idx;
   logic          w_unused_tags;

   // Scan oldest to youngest so the youngest matching entry is the last one written.
   always_comb begin
      w_match = 1'b0;
      w_avail = 1'b0;
      w_idx   = '0;
      for (int i = NUM_STAGES - 1; i >= 0; i--) begin
         if (i_used && i_tags[i].valid && i_tags[i].regwrite &&
             (i_tags[i].rd == i_rs) && (i_tags[i].rd != '0)) begin
            w_match = 1'b1;
            w_idx   = IW'(i);
            // A load result only exists from LOAD_STAGE onward.
            w_avail = !i_tags[i].memread || (i >= LOAD_STAGE);
         end
      end
   end

   assign w_unused_tags = ^i_tags;

   assign o_match = w_match;
   assign o_avail = w_avail;
   assign o_idx   = w_idx;

endmodule

// File: rtl/pipeline_hazard_unit.sv
// rtl/pipeline_hazard_unit.sv - stall/flush/forward controller beside ID (PIPE_FORWARD_EN enables forwarding)
module pipeline_hazard_unit
   import cpu_types_pkg::*;
#(
   parameter int NUM_STAGES = 3,
   parameter int NUM_SRC    = 2,
   parameter int REG_AW     = 5,
   parameter int LOAD_STAGE = 1
) (
   input logic                  CLK,
   input logic                  RST,
   pipeline_hazard_unit_if.slave hz
);

   localparam int FW = $clog2(NUM_STAGES + 1);
   localparam int IW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

`ifdef PIPE_FORWARD_EN
   localparam bit FWD_ON = 1'b1;
`else
   // Without forwarding every producer hit blocks ID until the producer retires.
   localparam bit FWD_ON = 1'b0;
`endif

   hz_tag_t [NUM_STAGES-1:0]       r_tags;
   logic                           r_halted;

   hz_tag_t                        w_new_tag;
   logic [NUM_SRC-1:0]             w_match;
   logic [NUM_SRC-1:0]             w_avail;
   logic [NUM_SRC-1:0]             w_block;
   logic [NUM_SRC-1:0][IW-1:0]     w_idx;
   logic [NUM_SRC*FW-1:0]          w_fwd;
   logic                           w_hazard;
   logic                           w_pc_write;
   logic                           w_if_id_write;
   logic                           w_if_id_flush;
   logic                           w_id_ex_bubble;
   logic                           w_pipe_adv;
   logic                           w_stall;
   logic [NUM_SRC*FW-1:0]          w_fwd_sel;

   for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
      hazard_src_match #(
         .NUM_STAGES (NUM_STAGES),
         .LOAD_STAGE (LOAD_STAGE),
         .IW         (IW)
      ) u_match (
         .i_tags  (r_tags),
         .i_rs    (regbits_t'(hz.id_rs[s*REG_AW +: REG_AW])),
         .i_used  (hz.id_rs_used[s]),
         .o_idx   (w_idx[s]),
         .o_match (w_match[s]),
         .o_avail (w_avail[s])
      );

      assign w_block[s] = w_match[s] && !(w_avail[s] && FWD_ON);
      assign w_fwd[s*FW +: FW] = (w_match[s] && w_avail[s] && FWD_ON) ?
                                 FW'(w_idx[s]) + FW'(1) : FW'(FWD_RF);
   end

   assign w_hazard = |w_block;

   // Prioritised enable generation: reset, halt, data wait, redirect, stall, fetch wait, normal.
   always_comb begin
      w_pc_write     = 1'b0;
      w_if_id_write  = 1'b0;
      w_if_id_flush  = 1'b0;
      w_id_ex_bubble = 1'b0;
      w_pipe_adv     = 1'b0;
      w_stall        = 1'b0;
      w_fwd_sel      = w_fwd;
      if (RST) begin
         w_if_id_flush  = 1'b1;
         w_id_ex_bubble = 1'b1;
         w_fwd_sel      = '0;
      end else if (r_halted) begin
         w_pc_write = 1'b0;
      end else if (hz.dmem_wait) begin
         w_pipe_adv = 1'b0;
      end else if (hz.redirect) begin
         w_pc_write     = 1'b1;
         w_if_id_write  = 1'b1;
         w_if_id_flush  = 1'b1;
         w_id_ex_bubble = 1'b1;
         w_pipe_adv     = 1'b1;
      end else if (w_hazard) begin
         w_id_ex_bubble = 1'b1;
         w_pipe_adv     = 1'b1;
         w_stall        = 1'b1;
      end else if (hz.imem_wait) begin
         w_if_id_write = 1'b1;
         w_if_id_flush = 1'b1;
         w_pipe_adv    = 1'b1;
      end else begin
         w_pc_write    = 1'b1;
         w_if_id_write = 1'b1;
         w_pipe_adv    = 1'b1;
      end
   end

   // Tag entering entry 0 from ID; bubbles enter as invalid.
   always_comb begin
      w_new_tag          = '0;
      w_new_tag.valid    = hz.id_valid && !w_id_ex_bubble;
      w_new_tag.rd       = regbits_t'(hz.id_rd);
      w_new_tag.regwrite = hz.id_regwrite;
      w_new_tag.memread  = hz.id_memread;
      w_new_tag.halt     = hz.id_halt;
   end

   // Shadow tag pipeline shifts with the datapath; halt latches as it retires.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_tags   <= '0;
         r_halted <= 1'b0;
      end else if (w_pipe_adv) begin
         r_tags[0] <= w_new_tag;
         for (int i = 1; i < NUM_STAGES; i++) begin
            r_tags[i] <= r_tags[i-1];
         end
         if (r_tags[NUM_STAGES-1].valid && r_tags[NUM_STAGES-1].halt) begin
            r_halted <= 1'b1;
         end
      end
   end

   assign hz.pc_write     = w_pc_write;
   assign hz.if_id_write  = w_if_id_write;
   assign hz.if_id_flush  = w_if_id_flush;
   assign hz.id_ex_bubble = w_id_ex_bubble;
   assign hz.pipe_adv     = w_pipe_adv;
   assign hz.fwd_sel      = w_fwd_sel;
   assign hz.stall        = w_stall;
   assign hz.halted       = r_halted && !RST;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// tb/tb_pipeline_hazard_unit.sv - directed bench for pipeline_hazard_unit
module tb_pipeline_hazard_unit;

`ifdef PIPE_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   // {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_adv}
   localparam logic [4:0] E_NORM   = 5'b11001;
   localparam logic [4:0] E_RST    = 5'b00110;
   localparam logic [4:0] E_STALL  = 5'b00011;
   localparam logic [4:0] E_REDIR  = 5'b11111;
   localparam logic [4:0] E_IWAIT  = 5'b01101;
   localparam logic [4:0] E_OFF    = 5'b00000;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   pipeline_hazard_unit_if #(.NUM_STAGES(3), .NUM_SRC(2), .REG_AW(5)) hz();

   pipeline_hazard_unit #(
      .NUM_STAGES (3),
      .NUM_SRC    (2),
      .REG_AW     (5),
      .LOAD_STAGE (1)
   ) dut (
      .CLK (clk),
      .RST (rst),
      .hz  (hz)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_en(input string tag, input logic [4:0] exp);
      check_eq(tag, 32'({hz.pc_write, hz.if_id_write, hz.if_id_flush,
                         hz.id_ex_bubble, hz.pipe_adv}), 32'(exp));
   endtask

   task automatic drive_id(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                           input logic [1:0] used, input logic [4:0] rd,
                           input logic rw, input logic mr, input logic ht);
      hz.id_valid    = v;
      hz.id_rs       = {rs1, rs0};
      hz.id_rs_used  = used;
      hz.id_rd       = rd;
      hz.id_regwrite = rw;
      hz.id_memread  = mr;
      hz.id_halt     = ht;
   endtask

   task automatic idle();
      drive_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      repeat (4) begin
         tick();
         idle();
      end
   endtask

   int exp_fwd4[4];
   int exp_stl4[4];

   initial begin
      rst          = 1'b1;
      hz.redirect  = 1'b0;
      hz.imem_wait = 1'b0;
      hz.dmem_wait = 1'b0;
      idle();

      // Reset state with a would-be hazard presented in ID.
      tick();
      drive_id(1'b1, 5'd5, 5'd6, 2'b11, 5'd7, 1'b1, 1'b1, 1'b0);
      #2;
      check_en("rst_en", E_RST);
      check_eq("rst_fwd", 32'(hz.fwd_sel), 32'd0);
      check_eq("rst_stall", 32'(hz.stall), 32'd0);
      check_eq("rst_halted", 32'(hz.halted), 32'd0);
      tick();
      rst = 1'b0;
      idle();
      #2;
      check_en("idle_en", E_NORM);

      // Fetch wait.
      tick();
      drive_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd9, 1'b1, 1'b0, 1'b0);
      hz.imem_wait = 1'b1;
      #2;
      check_en("iwait_en", E_IWAIT);
      tick();
      hz.imem_wait = 1'b0;
      idle();
      drain();

      // ALU producer then dependent.
      tick();
      drive_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0, 1'b0);
      #2;
      check_en("t1_prod_en", E_NORM);
      tick();
      drive_id(1'b1, 5'd5, 5'd1, 2'b11, 5'd7, 1'b1, 1'b0, 1'b0);
      #2;
      check_eq("t1_fwd", 32'(hz.fwd_sel), FWD ? 32'd1 : 32'd0);
      check_eq("t1_stall", 32'(hz.stall), FWD ? 32'd0 : 32'd1);
      check_en("t1_en", FWD ? E_NORM : E_STALL);
      drain();

      // Two producers of x5: the younger wins.
      tick();
      drive_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0, 1'b0);
      tick();
      drive_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0, 1'b0);
      tick();
      drive_id(1'b1, 5'd5, 5'd0, 2'b01, 5'd8, 1'b1, 1'b0, 1'b0);
      #2;
      check_eq("young_fwd", 32'(hz.fwd_sel), FWD ? 32'd1 : 32'd0);
      check_eq("young_stall", 32'(hz.stall), FWD ? 32'd0 : 32'd1);
      drain();

      // Load then dependent: one bubble, then forward from MEM.
      tick();
      drive_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd6, 1'b1, 1'b1, 1'b0);
      #2;
      check_en("t2_lw_en", E_NORM);
      tick();
      drive_id(1'b1, 5'd6, 5'd6, 2'b11, 5'd7, 1'b1, 1'b0, 1'b0);
      #2;
      check_eq("t2_c2_stall", 32'(hz.stall), 32'd1);
      check_en("t2_c2_en", E_STALL);
      check_eq("t2_c2_fwd", 32'(hz.fwd_sel), 32'd0);
      tick();
      #2;
      check_eq("t2_c3_fwd", 32'(hz.fwd_sel), FWD ? 32'hA : 32'd0);
      check_eq("t2_c3_stall", 32'(hz.stall), FWD ? 32'd0 : 32'd1);
      drain();

      // x0 is never a hazard.
      tick();
      drive_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 1'b0, 1'b0);
      tick();
      drive_id(1'b1, 5'd0, 5'd0, 2'b11, 5'd7, 1'b1, 1'b0, 1'b0);
      #2;
      check_eq("x0_fwd", 32'(hz.fwd_sel), 32'd0);
      check_eq("x0_stall", 32'(hz.stall), 32'd0);
      check_en("x0_en", E_NORM);
      drain();

      // Data wait for four cycles with a dependent in ID.
      tick();
      drive_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0, 1'b0);
      tick();
      drive_id(1'b1, 5'd5, 5'd1, 2'b11, 5'd7, 1'b1, 1'b0, 1'b0);
      hz.dmem_wait = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #2;
         check_en($sformatf("dw_en%0d", k), E_OFF);
         check_eq($sformatf("dw_fwd%0d", k), 32'(hz.fwd_sel), FWD ? 32'd1 : 32'd0);
         tick();
      end
      hz.dmem_wait = 1'b0;
      exp_fwd4 = FWD ? '{1, 2, 3, 0} : '{0, 0, 0, 0};
      exp_stl4 = FWD ? '{0, 0, 0, 0} : '{1, 1, 1, 0};
      for (int k = 0; k < 4; k++) begin
         if (k > 0) tick();
         #2;
         check_eq($sformatf("dw_post_adv%0d", k), 32'(hz.pipe_adv), 32'd1);
         check_eq($sformatf("dw_post_fwd%0d", k), 32'(hz.fwd_sel), 32'(exp_fwd4[k]));
         check_eq($sformatf("dw_post_stall%0d", k), 32'(hz.stall), 32'(exp_stl4[k]));
      end
      drain();

      // Redirect over a load-use stall, then a second redirect back to back.
      tick();
      drive_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd6, 1'b1, 1'b1, 1'b0);
      tick();
      drive_id(1'b1, 5'd6, 5'd6, 2'b11, 5'd7, 1'b1, 1'b0, 1'b0);
      hz.redirect = 1'b1;
      #2;
      check_en("rd1_en", E_REDIR);
      check_eq("rd1_stall", 32'(hz.stall), 32'd0);
      tick();
      idle();
      #2;
      check_en("rd2_en", E_REDIR);
      tick();
      hz.redirect = 1'b0;
      #2;
      check_en("rd3_en", E_NORM);
      drain();

      // Halt retires four cycles after entering ID.
      tick();
      drive_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b1);
      #2;
      check_eq("h0_halted", 32'(hz.halted), 32'd0);
      tick();
      idle();
      tick();
      tick();
      #2;
      check_eq("h3_halted", 32'(hz.halted), 32'd0);
      check_en("h3_en", E_NORM);
      tick();
      #2;
      check_eq("h4_halted", 32'(hz.halted), 32'd1);
      check_en("h4_en", E_OFF);
      tick();
      drive_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0, 1'b0);
      #2;
      check_eq("h5_halted", 32'(hz.halted), 32'd1);
      check_en("h5_en", E_OFF);
      tick();
      rst = 1'b1;
      #2;
      check_eq("h_rst_halted", 32'(hz.halted), 32'd0);
      check_en("h_rst_en", E_RST);
      tick();
      rst = 1'b0;
      #2;
      check_eq("h_post_halted", 32'(hz.halted), 32'd0);
      check_en("h_post_en", E_NORM);

      // Mid-stream reset discards the in-flight producer.
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      drive_id(1'b1, 5'd5, 5'd0, 2'b01, 5'd7, 1'b1, 1'b0, 1'b0);
      #2;
      check_eq("mrst_fwd", 32'(hz.fwd_sel), 32'd0);
      check_eq("mrst_stall", 32'(hz.stall), 32'd0);
      check_en("mrst_en", E_NORM);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
